// File: rtl/params_noc.sv
// Shared NoC types: flit labels, VC ids, packet header and the VC-tagged flit
// that goes to the router LOCAL port.
package params_noc;

  localparam int unsigned vc_Num    = 4;
  localparam int unsigned VC_W      = 2;
  localparam int unsigned FLIT_W    = 22;
  localparam int unsigned COORD_W   = 3;
  localparam int unsigned PAYLOAD_W = 16;

  typedef logic [VC_W-1:0]   VC_Size;
  typedef logic [FLIT_W-1:0] flit_Size;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_Data_Label;

  typedef struct packed {
    logic [COORD_W-1:0]   x_Dest;
    logic [COORD_W-1:0]   y_Dest;
    logic [PAYLOAD_W-1:0] head_Payload;
  } packet_Header;

  // Head flits carry the header; body/tail flits carry a raw word.
  typedef union packed {
    packet_Header head_Data;
    flit_Size     flit;
  } flit_Data_Union;

  typedef struct packed {
    flit_Data_Label label;
    VC_Size         vc_Id;
    flit_Data_Union data;
  } flit_Data_withvc;

endpackage

// File: rtl/ni_credit_counter.sv
// Per-VC credit counters for the downstream router input buffers, with
// registered nonzero flags and an overflow error pulse.
module ni_credit_counter
  import params_noc::*;
#(
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              take_i,
  input  VC_Size            take_vc_i,
  input  logic              ret_valid_i,
  input  VC_Size            ret_vc_i,
  output logic [vc_Num-1:0] nonzero_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [vc_Num-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [vc_Num-1:0]            nonzero_q, nonzero_d;
  logic [vc_Num-1:0]            take_v, ret_v;
  logic                         err_q, err_d;

  always_comb begin
    take_v = '0;
    ret_v  = '0;
    if (take_i)      take_v[take_vc_i] = 1'b1;
    if (ret_valid_i) ret_v[ret_vc_i]   = 1'b1;
  end

  // Launch and return on the same VC cancel; a return at full depth is an error.
  always_comb begin
    cnt_d     = cnt_q;
    nonzero_d = '0;
    err_d     = 1'b0;
    for (int v = 0; v < int'(vc_Num); v++) begin
      if (take_v[v] && !ret_v[v]) begin
        cnt_d[v] = cnt_q[v] - CNT_W'(1);
      end else if (ret_v[v] && !take_v[v]) begin
        if (cnt_q[v] == CNT_W'(BUF_DEPTH)) err_d = 1'b1;
        else                               cnt_d[v] = cnt_q[v] + CNT_W'(1);
      end
      nonzero_d[v] = (cnt_d[v] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < int'(vc_Num); v++) cnt_q[v] <= CNT_W'(BUF_DEPTH);
      nonzero_q <= {vc_Num{BUF_DEPTH != 0}};
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      nonzero_q <= nonzero_d;
      err_q     <= err_d;
    end
  end

  assign nonzero_o = nonzero_q;
  assign err_o     = err_q;

endmodule

// File: rtl/ni_packetizer.sv
// Network-interface packetizer: turns a header + length request and a stream
// of body words into credit-flow-controlled HEAD/BODY/TAIL flits on one VC.
module ni_packetizer
  import params_noc::*;
#(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned LEN_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_valid_i,
  output logic             pkt_ready_o,
  input  packet_Header     pkt_header_i,
  input  logic [LEN_W-1:0] pkt_len_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  input  flit_Size         data_i,
  output flit_Data_withvc  flit_o,
  output logic             flit_valid_o,
  input  logic             credit_valid_i,
  input  VC_Size           credit_vc_i,
  output logic             credit_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  logic [1:0]        state_q, state_d;
  packet_Header      hdr_q, hdr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_nxt;
  VC_Size            vc_q, vc_d;
  flit_Data_withvc   flit_q, flit_d;
  logic              flit_valid_q, flit_valid_d;
  logic              credit_err_q;

  logic [vc_Num-1:0] nonzero;
  logic              cc_err;
  logic              take;
  VC_Size            take_vc;
  logic              sel_found;
  VC_Size            sel_vc;
  logic              pkt_ready_c, data_ready_c;

  ni_credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_credit (
    .clk         (clk),
    .rst         (rst),
    .take_i      (take),
    .take_vc_i   (take_vc),
    .ret_valid_i (credit_valid_i),
    .ret_vc_i    (credit_vc_i),
    .nonzero_o   (nonzero),
    .err_o       (cc_err)
  );

  // Lowest-index VC with credit wins.
  always_comb begin
    sel_found = |nonzero;
    sel_vc    = '0;
    for (int v = int'(vc_Num) - 1; v >= 0; v--) begin
      if (nonzero[v]) sel_vc = VC_Size'(v);
    end
  end

  assign cnt_nxt = cnt_q + LEN_W'(1);

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    vc_d         = vc_q;
    flit_d       = flit_q;
    flit_valid_d = 1'b0;
    take         = 1'b0;
    take_vc      = vc_q;
    pkt_ready_c  = 1'b0;
    data_ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        pkt_ready_c = 1'b1;
        if (pkt_valid_i) begin
          hdr_d   = pkt_header_i;
          len_d   = pkt_len_i;
          cnt_d   = '0;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        if (sel_found) begin
          take                  = 1'b1;
          take_vc               = sel_vc;
          vc_d                  = sel_vc;
          flit_valid_d          = 1'b1;
          flit_d.label          = (len_q == '0) ? HEADTAIL : HEAD;
          flit_d.vc_Id          = sel_vc;
          flit_d.data.head_Data = hdr_q;
          state_d               = (len_q == '0) ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        data_ready_c = data_valid_i & nonzero[vc_q];
        if (data_ready_c) begin
          take             = 1'b1;
          flit_valid_d     = 1'b1;
          flit_d.vc_Id     = vc_q;
          flit_d.data.flit = data_i;
          if (cnt_nxt == len_q) begin
            flit_d.label = TAIL;
            cnt_d        = '0;
            state_d      = S_IDLE;
          end else begin
            flit_d.label = BODY;
            cnt_d        = cnt_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hdr_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      vc_q         <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      vc_q         <= vc_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      credit_err_q <= credit_err_q | cc_err;
    end
  end

  assign pkt_ready_o  = pkt_ready_c;
  assign data_ready_o = data_ready_c;
  assign flit_o       = flit_q;
  assign flit_valid_o = flit_valid_q;
  assign credit_err_o = credit_err_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: header/body sequencing, VC choice under
// credit pressure, credit overflow and mid-packet reset.
module tb_ni_packetizer;
  import params_noc::*;

  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned LEN_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             pkt_valid;
  logic             pkt_ready;
  packet_Header     pkt_header;
  logic [LEN_W-1:0] pkt_len;
  logic             data_valid;
  logic             data_ready;
  flit_Size         data;
  flit_Data_withvc  flit;
  logic             flit_valid;
  logic             credit_valid;
  VC_Size           credit_vc;
  logic             credit_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ni_packetizer #(.BUF_DEPTH(BUF_DEPTH), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pkt_valid_i    (pkt_valid),
    .pkt_ready_o    (pkt_ready),
    .pkt_header_i   (pkt_header),
    .pkt_len_i      (pkt_len),
    .data_valid_i   (data_valid),
    .data_ready_o   (data_ready),
    .data_i         (data),
    .flit_o         (flit),
    .flit_valid_o   (flit_valid),
    .credit_valid_i (credit_valid),
    .credit_vc_i    (credit_vc),
    .credit_err_o   (credit_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic packet_Header mk_hdr(input int x, input int y, input int p);
    packet_Header h;
    h.x_Dest       = COORD_W'(x);
    h.y_Dest       = COORD_W'(y);
    h.head_Payload = PAYLOAD_W'(p);
    return h;
  endfunction

  function automatic logic [63:0] credit_of(input int v);
    return 64'(dut.u_credit.cnt_q[v]);
  endfunction

  // Sends one packet with body words 1..len and checks every flit on the expected VC.
  task automatic send_pkt(input packet_Header h, input logic [LEN_W-1:0] len,
                          input VC_Size vc, input string tag);
    flit_Data_withvc e;
    bit seen;
    pkt_valid  = 1'b1;
    pkt_header = h;
    pkt_len    = len;
    data_valid = 1'b1;
    data       = 22'h3FFFFF;
    tick;
    pkt_valid = 1'b0;
    chk({tag, ".ready_in_head"}, 64'(data_ready), 64'(0));
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick;
      seen = flit_valid;
    end
    chk({tag, ".head_seen"}, 64'(seen), 64'(1));
    if (!seen) begin
      data_valid = 1'b0;
      return;
    end
    e                = '0;
    e.label          = (len == '0) ? HEADTAIL : HEAD;
    e.vc_Id          = vc;
    e.data.head_Data = h;
    chk({tag, ".head_flit"}, 64'(flit), 64'(e));
    for (int j = 1; j <= int'(len); j++) begin
      data = 22'(j);
      tick;
      chk({tag, ".body_valid"}, 64'(flit_valid), 64'(1));
      e.label     = (j == int'(len)) ? TAIL : BODY;
      e.data.flit = 22'(j);
      chk({tag, ".body_flit"}, 64'(flit), 64'(e));
    end
    data_valid = 1'b0;
    tick;
    chk({tag, ".idle_valid"}, 64'(flit_valid), 64'(0));
    chk({tag, ".flit_hold"}, 64'(flit), 64'(e));
    chk({tag, ".pkt_ready"}, 64'(pkt_ready), 64'(1));
  endtask

  initial begin
    flit_Data_withvc e;
    rst          = 1'b1;
    pkt_valid    = 1'b0;
    pkt_header   = '0;
    pkt_len      = '0;
    data_valid   = 1'b0;
    data         = '0;
    credit_valid = 1'b0;
    credit_vc    = '0;

    // Reset state
    tick;
    tick;
    chk("rst.flit_valid", 64'(flit_valid), 64'(0));
    chk("rst.flit", 64'(flit), 64'(0));
    chk("rst.credit_err", 64'(credit_err), 64'(0));
    for (int v = 0; v < 4; v++) chk($sformatf("rst.credit%0d", v), credit_of(v), 64'(4));
    rst = 1'b0;
    tick;
    chk("rst.pkt_ready", 64'(pkt_ready), 64'(1));

    // Single HEADTAIL flit
    pkt_valid  = 1'b1;
    pkt_header = mk_hdr(2, 5, 16'hBEEF);
    pkt_len    = '0;
    tick;
    pkt_valid = 1'b0;
    chk("ht.pkt_ready_head", 64'(pkt_ready), 64'(0));
    chk("ht.no_flit_yet", 64'(flit_valid), 64'(0));
    tick;
    e                = '0;
    e.label          = HEADTAIL;
    e.vc_Id          = 2'd0;
    e.data.head_Data = mk_hdr(2, 5, 16'hBEEF);
    chk("ht.valid", 64'(flit_valid), 64'(1));
    chk("ht.flit", 64'(flit), 64'(e));
    chk("ht.credit0", credit_of(0), 64'(3));
    tick;
    chk("ht.valid_drop", 64'(flit_valid), 64'(0));

    // Credit return to VC0 brings it back to full without error
    credit_valid = 1'b1;
    credit_vc    = 2'd0;
    tick;
    credit_valid = 1'b0;
    chk("ret.credit0", credit_of(0), 64'(4));
    tick;
    tick;
    chk("ret.no_err", 64'(credit_err), 64'(0));

    // len=3 back-to-back on VC0
    send_pkt(mk_hdr(1, 1, 16'h1234), 4'd3, 2'd0, "p3");
    chk("p3.credit0", credit_of(0), 64'(0));

    // VC0 empty -> VC1 chosen, VC0 untouched
    send_pkt(mk_hdr(3, 4, 16'hCAFE), 4'd1, 2'd1, "p1");
    chk("p1.credit0", credit_of(0), 64'(0));
    chk("p1.credit1", credit_of(1), 64'(2));

    // Drain the remaining credits
    send_pkt(mk_hdr(0, 7, 16'h0001), 4'd1, 2'd1, "d1");
    send_pkt(mk_hdr(0, 7, 16'h0002), 4'd3, 2'd2, "d2");
    send_pkt(mk_hdr(0, 7, 16'h0003), 4'd3, 2'd3, "d3");
    chk("d.credit3", credit_of(3), 64'(0));

    // Stall in HEAD with no credit, then a returned credit on VC2 unblocks it
    pkt_valid  = 1'b1;
    pkt_header = mk_hdr(4, 6, 16'hA5A5);
    pkt_len    = '0;
    tick;
    pkt_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stall.no_flit", 64'(flit_valid), 64'(0));
    end
    credit_valid = 1'b1;
    credit_vc    = 2'd2;
    tick;
    credit_valid = 1'b0;
    chk("stall.not_yet", 64'(flit_valid), 64'(0));
    tick;
    e                = '0;
    e.label          = HEADTAIL;
    e.vc_Id          = 2'd2;
    e.data.head_Data = mk_hdr(4, 6, 16'hA5A5);
    chk("stall.valid", 64'(flit_valid), 64'(1));
    chk("stall.flit", 64'(flit), 64'(e));
    chk("stall.credit2", credit_of(2), 64'(0));

    // Reset mid-packet after the second flit of a len=5 packet
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    pkt_valid  = 1'b1;
    pkt_header = mk_hdr(5, 5, 16'h5555);
    pkt_len    = 4'd5;
    data_valid = 1'b1;
    data       = 22'h11;
    tick;
    pkt_valid = 1'b0;
    tick;
    chk("mr.head_valid", 64'(flit_valid), 64'(1));
    tick;
    chk("mr.body_valid", 64'(flit_valid), 64'(1));
    chk("mr.body_label", 64'(flit.label), 64'(BODY));
    rst = 1'b1;
    tick;
    chk("mr.valid_rst", 64'(flit_valid), 64'(0));
    for (int v = 0; v < 4; v++) chk($sformatf("mr.credit%0d", v), credit_of(v), 64'(4));
    rst        = 1'b0;
    data_valid = 1'b0;
    tick;
    chk("mr.pkt_ready", 64'(pkt_ready), 64'(1));
    chk("mr.flit_zero", 64'(flit), 64'(0));
    chk("mr.err_clear", 64'(credit_err), 64'(0));
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("mr.no_tail", 64'(flit_valid), 64'(0));
    end

    // Launch and return on VC0 in the same cycle leave it at full depth, no error
    pkt_valid  = 1'b1;
    pkt_header = mk_hdr(1, 2, 16'h0F0F);
    pkt_len    = '0;
    tick;
    pkt_valid    = 1'b0;
    credit_valid = 1'b1;
    credit_vc    = 2'd0;
    tick;
    credit_valid = 1'b0;
    chk("sim.valid", 64'(flit_valid), 64'(1));
    chk("sim.vc", 64'(flit.vc_Id), 64'(0));
    chk("sim.credit0", credit_of(0), 64'(4));
    tick;
    tick;
    chk("sim.no_err", 64'(credit_err), 64'(0));

    // Overflow on VC3 is sticky and the counter saturates
    credit_valid = 1'b1;
    credit_vc    = 2'd3;
    tick;
    credit_valid = 1'b0;
    tick;
    tick;
    chk("ovf.err", 64'(credit_err), 64'(1));
    chk("ovf.credit3", credit_of(3), 64'(4));
    repeat (5) tick;
    chk("ovf.sticky", 64'(credit_err), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
